// File: rtl/delay_4_rd_8b_if.sv
// Handshake bundle between the delay-chain read side, its upstream chains and the consumer.
// The slave modport is the buffer's own view.
interface delay_4_rd_8b_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
);
    logic                       in_valid;
    logic [W-1:0]               in_data;
    logic                       in_flag;
    logic                       hold;
    logic                       out_valid;
    logic [W-1:0]               out_data;
    logic                       out_flag;
    logic                       out_ready;
    logic [$clog2(DEPTH):0]     level;

    modport slave (
        input  in_valid, in_data, in_flag, out_ready,
        output hold, out_valid, out_data, out_flag, level
    );

    modport master (
        output in_valid, in_data, in_flag, out_ready,
        input  hold, out_valid, out_data, out_flag, level
    );
endinterface

// File: rtl/delay_4_rd_8b.sv
// First-word-fall-through buffer capturing {flag, data} from the delay chains.
// It stalls the chains via hold while full.
module delay_4_rd_8b #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    delay_4_rd_8b_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

    logic [W:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full, empty, push, pop;

    // hold is decoded only from count_q, so out_ready never reaches it combinationally
    assign full  = (count_q == Full);
    assign empty = (count_q == '0);
    assign push  = bus.in_valid & ~full;
    assign pop   = ~empty & bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.in_flag, bus.in_data};
    end

    assign bus.hold      = full;
    assign bus.out_valid = ~empty;
    assign bus.out_data  = mem_q[rd_ptr_q][W-1:0];
    assign bus.out_flag  = mem_q[rd_ptr_q][W];
    assign bus.level     = count_q;
endmodule

// File: tb/tb_delay_4_rd_8b.sv
// Bench for delay_4_rd_8b: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_delay_4_rd_8b;
    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    delay_4_rd_8b_if #(.W(W), .DEPTH(DEPTH)) bus ();

    delay_4_rd_8b #(.W(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {flag, data} words.
    logic [W:0] mq[$];

    always @(posedge clk or negedge rst_n) begin : model
        bit do_push;
        bit do_pop;
        if (!rst_n) begin
            mq.delete();
        end else begin
            do_push = bus.in_valid && (mq.size() < DEPTH);
            do_pop  = bus.out_ready && (mq.size() > 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({bus.in_flag, bus.in_data});
        end
    end

    // Compare process, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("level", 32'(bus.level), 32'(mq.size()));
            chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
            chk("hold", 32'(bus.hold), 32'(mq.size() == DEPTH));
            if (mq.size() != 0)
                chk("head", 32'({bus.out_flag, bus.out_data}), 32'(mq[0]));
        end
    end

    // Apply inputs, let one edge take them, return 1 time unit after that edge
    task automatic drive(input logic v, input logic [W-1:0] d, input logic f, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_flag   = f;
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] got [4];
    logic [W-1:0] exp_seq [4];
    logic         hold_seen;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_flag   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", 32'(bus.hold), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        rst_n = 1'b1;

        // Mid-stream asynchronous reset at level 3
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        chk("pre_rst_level", 32'(bus.level), 32'd3);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.out_valid), 32'd0);
        chk("async_hold", 32'(bus.hold), 32'd0);
        chk("async_level", 32'(bus.level), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("first_data", 32'(bus.out_data), 32'h5A);
        chk("first_flag", 32'(bus.out_flag), 32'd1);
        chk("first_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("drained", 32'(bus.level), 32'd0);

        // Fill and stall
        for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_hold", 32'(bus.hold), 32'd1);
        chk("fill_level", 32'(bus.level), 32'd4);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h05, 1'b0, 1'b0);
        chk("stall_level", 32'(bus.level), 32'd4);
        chk("stall_head", 32'(bus.out_data), 32'h01);

        // Release from full: pop frees a slot, 0x05 enters on the next edge
        drive(1'b1, 8'h05, 1'b0, 1'b1);
        chk("release_hold", 32'(bus.hold), 32'd0);
        chk("release_level", 32'(bus.level), 32'd3);
        chk("release_head", 32'(bus.out_data), 32'h02);
        drive(1'b1, 8'h05, 1'b0, 1'b0);
        chk("refill_level", 32'(bus.level), 32'd4);
        exp_seq[0] = 8'h02; exp_seq[1] = 8'h03; exp_seq[2] = 8'h04; exp_seq[3] = 8'h05;
        for (int k = 0; k < 4; k++) begin
            got[k] = bus.out_data;
            drive(1'b0, 8'h00, 1'b0, 1'b1);
        end
        for (int k = 0; k < 4; k++) chk($sformatf("release_seq%0d", k), 32'(got[k]), 32'(exp_seq[k]));
        chk("release_empty", 32'(bus.out_valid), 32'd0);

        // Streaming with wrap-around
        hold_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(i), 1'(i % 2), 1'b1);
            if (bus.hold) hold_seen = 1'b1;
            if (bus.level != 1 || bus.out_data != 8'(i))
                chk($sformatf("stream%0d", i), 32'({bus.level, bus.out_data}), 32'({3'd1, 8'(i)}));
        end
        chk("stream_level", 32'(bus.level), 32'd1);
        chk("stream_last", 32'(bus.out_data), 32'h13);
        chk("stream_no_hold", 32'(hold_seen), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous push/pop at level 2, then pop on empty
        drive(1'b1, 8'hA0, 1'b0, 1'b0);
        drive(1'b1, 8'hA1, 1'b1, 1'b0);
        drive(1'b1, 8'hA2, 1'b0, 1'b1);
        chk("pp_level", 32'(bus.level), 32'd2);
        chk("pp_head", 32'({bus.out_flag, bus.out_data}), 32'h1A1);
        drive(1'b1, 8'hA3, 1'b1, 1'b1);
        chk("pp_level2", 32'(bus.level), 32'd2);
        chk("pp_head2", 32'(bus.out_data), 32'hA2);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("underflow_level", 32'(bus.level), 32'd0);
        chk("underflow_valid", 32'(bus.out_valid), 32'd0);

        // Random backpressure against the model
        for (int i = 0; i < 1000; i++)
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("final_level", 32'(bus.level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
